pixel_stream_driver: RTL and testbench



---
 rtl/pixel_stream_pkg.sv | 19 +
 rtl/frame_buffer.sv | 37 +++
 rtl/pixel_stream_driver.sv | 165 ++++++++++++++++
 tb/tb_pixel_stream_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared types and default geometry for the kernel-RAM pixel stream driver.
package pixel_stream_pkg;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned BIT_SIZE_DEFAULT = 6;
  localparam int unsigned HOLD_DEFAULT = 2;
  localparam int unsigned FRAME = N_DEFAULT * N_DEFAULT;
  localparam int unsigned ADDR_W = BIT_SIZE_DEFAULT + 1;

  typedef enum logic [2:0] {
    StLoad,
    StReady,
    StBroadcast,
    StGap,
    StReadout,
    StDone
  } state_e;

endpackage

// File: rtl/frame_buffer.sv
// One-frame pixel store: single write port, single read port, one-cycle registered read.
module frame_buffer #(
  parameter int unsigned Depth = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  logic [7:0] mem [Depth];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port idles at zero so the driven data bus is quiet outside the broadcast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= 8'h00;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= 8'h00;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_stream_driver.sv
// Buffers one frame, broadcasts it to the kernel RAM bank, then reads the per-pixel results back.
module pixel_stream_driver
  import pixel_stream_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned BIT_SIZE = BIT_SIZE_DEFAULT,
  parameter int unsigned HOLD     = HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [7:0]        load_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic              re,
  output logic [BIT_SIZE:0] pixel_position_or_address,
  output logic [7:0]        data_out,
  input  logic [7:0]        result_in,
  output logic              result_valid,
  output logic [7:0]        result_data,
  output logic [BIT_SIZE:0] result_addr
);

  localparam int unsigned FrameLen = N * N;
  localparam int unsigned AddrW    = BIT_SIZE + 1;
  localparam int unsigned IdxW     = $clog2(FrameLen);
  localparam int unsigned HoldW    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AddrW-1:0] AddrLast = AddrW'(FrameLen - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [AddrW-1:0] load_cnt_q, load_cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             we_q, re_q, busy_q, done_q, load_ready_q;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [AddrW-1:0] res_addr_q, res_addr_d;
  logic             buf_wr_en;
  logic             hold_last, addr_last;

  assign hold_last = (hold_q == HoldLast);
  assign addr_last = (addr_q == AddrLast);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    load_cnt_d  = load_cnt_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;
    buf_wr_en   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (load_valid && load_ready_q) begin
          buf_wr_en  = 1'b1;
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == AddrLast) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        if (start) begin
          state_d = StBroadcast;
          addr_d  = '0;
          hold_d  = '0;
        end
      end
      StBroadcast, StReadout: begin
        if (hold_last) begin
          hold_d = '0;
          if (addr_last) begin
            state_d = (state_q == StBroadcast) ? StGap : StDone;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          // The consumers have settled by the last cycle of each read window.
          if (state_q == StReadout) begin
            res_valid_d = 1'b1;
            res_data_d  = result_in;
            res_addr_d  = addr_q;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StGap: begin
        if (hold_last) begin
          hold_d  = '0;
          state_d = StReadout;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StDone: begin
        state_d    = StLoad;
        addr_d     = '0;
        hold_d     = '0;
        load_cnt_d = '0;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StLoad;
      addr_q       <= '0;
      hold_q       <= '0;
      load_cnt_q   <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= 8'h00;
      res_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      load_cnt_q   <= load_cnt_d;
      we_q         <= (state_d == StBroadcast);
      re_q         <= (state_d == StReadout);
      busy_q       <= (state_d == StBroadcast) || (state_d == StGap) || (state_d == StReadout);
      done_q       <= (state_d == StDone);
      load_ready_q <= (state_d == StLoad);
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_addr_q   <= res_addr_d;
    end
  end

  // Read address runs on the next-state address so data_out lands with its address.
  frame_buffer #(
    .Depth(FrameLen)
  ) u_frame_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (buf_wr_en),
    .wr_addr(load_cnt_q[IdxW-1:0]),
    .wr_data(load_data),
    .rd_en  (state_d == StBroadcast),
    .rd_addr(addr_d[IdxW-1:0]),
    .rd_data(data_out)
  );

  assign load_ready                = load_ready_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign we                        = we_q;
  assign re                        = re_q;
  assign pixel_position_or_address = addr_q;
  assign result_valid              = res_valid_q;
  assign result_data               = res_data_q;
  assign result_addr               = res_addr_q;

endmodule

// File: tb/tb_pixel_stream_driver.sv
// Randomised frame load/broadcast/readout bench against a frame-level reference of the bus stream.
module tb_pixel_stream_driver;
  import pixel_stream_pkg::*;

  localparam int unsigned HOLD = 2;
  localparam int unsigned AW   = ADDR_W;
  localparam int unsigned IW   = $clog2(FRAME);
  typedef logic [IW-1:0] idx_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    load_data = 8'h00;
  logic          load_ready, busy, done, we, re, result_valid;
  logic [7:0]    data_out, result_in, result_data;
  logic [AW-1:0] addr, result_addr;

  int checks = 0;
  int passed = 0;
  logic [7:0] img [FRAME];

  always #5 clk = ~clk;

  // Kernel RAM bank stand-in: each unit reports the inverse of its own address.
  assign result_in = re ? ~8'(addr) : 8'h00;

  pixel_stream_driver #(
    .N       (8),
    .BIT_SIZE(6),
    .HOLD    (HOLD)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .load_valid               (load_valid),
    .load_ready               (load_ready),
    .load_data                (load_data),
    .start                    (start),
    .busy                     (busy),
    .done                     (done),
    .we                       (we),
    .re                       (re),
    .pixel_position_or_address(addr),
    .data_out                 (data_out),
    .result_in                (result_in),
    .result_valid             (result_valid),
    .result_data              (result_data),
    .result_addr              (result_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_frame(input bit start_mid);
    int  sent = 0;
    int  guard = 0;
    logic lr;
    while (sent < int'(FRAME) && guard < 2000) begin
      guard++;
      load_valid = ($urandom_range(3) != 0);
      load_data  = img[idx_t'(sent)];
      start      = start_mid && (sent == 10);
      lr         = load_ready;
      @(negedge clk);
      if (load_valid && lr) sent++;
      if (start) begin
        chk("start_in_load_busy", 32'(busy), 32'(0));
        chk("start_in_load_ready", 32'(load_ready), 32'(1));
      end
    end
    load_valid = 1'b0;
    start      = 1'b0;
    chk("load_beats", 32'(sent), 32'(FRAME));
    chk("ready_load_ready", 32'(load_ready), 32'(0));
    chk("ready_busy", 32'(busy), 32'(0));
  endtask

  task automatic run_frame(input string name);
    logic [AW-1:0] bus_a[$];
    logic [7:0]    bus_d[$];
    logic [AW-1:0] res_a[$];
    logic [7:0]    res_d[$];
    int gap = 0, gap_bad = 0, busy_cnt = 0, dones = 0, lr_bad = 0;
    bit seen_done = 0;
    logic [7:0] e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_start"}, 32'(busy), 32'(1));
    for (int c = 0; c < 1000 && !seen_done; c++) begin
      if (busy) busy_cnt++;
      if (we) begin
        bus_a.push_back(addr);
        bus_d.push_back(data_out);
        if (load_ready) lr_bad++;
      end
      if (busy && !we && !re) begin
        gap++;
        if (addr != '0) gap_bad++;
      end
      if (result_valid) begin
        res_a.push_back(result_addr);
        res_d.push_back(result_data);
      end
      if (done) begin
        dones++;
        seen_done = 1;
      end
      // Junk load beats and stray starts while busy must be ignored.
      load_valid = we ? 1'($urandom_range(1)) : 1'b0;
      load_data  = 8'($urandom);
      start      = busy ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
    end
    load_valid = 1'b0;
    start      = 1'b0;
    chk({name, "_done_seen"}, 32'(seen_done), 32'(1));
    chk({name, "_done_count"}, 32'(dones), 32'(1));
    chk({name, "_post_done"}, 32'(done), 32'(0));
    chk({name, "_post_load_ready"}, 32'(load_ready), 32'(1));
    chk({name, "_post_we"}, 32'(we), 32'(0));
    chk({name, "_post_addr"}, 32'(addr), 32'(0));
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(2 * FRAME * HOLD + HOLD));
    chk({name, "_gap_cycles"}, 32'(gap), 32'(HOLD));
    chk({name, "_gap_addr"}, 32'(gap_bad), 32'(0));
    chk({name, "_bcast_load_ready"}, 32'(lr_bad), 32'(0));
    chk({name, "_bcast_len"}, 32'(bus_a.size()), 32'(FRAME * HOLD));
    for (int j = 0; j < bus_a.size() && j < int'(FRAME * HOLD); j++) begin
      chk($sformatf("%s_bus_addr[%0d]", name, j), 32'(bus_a[j]), 32'(j / HOLD));
      chk($sformatf("%s_bus_data[%0d]", name, j), 32'(bus_d[j]),
          32'(img[idx_t'(j / HOLD)]));
    end
    chk({name, "_result_count"}, 32'(res_a.size()), 32'(FRAME));
    for (int k = 0; k < res_a.size() && k < int'(FRAME); k++) begin
      e = ~8'(k);
      chk($sformatf("%s_res_addr[%0d]", name, k), 32'(res_a[k]), 32'(k));
      chk($sformatf("%s_res_data[%0d]", name, k), 32'(res_d[k]), 32'(e));
    end
  endtask

  task automatic reset_mid_broadcast();
    bit found = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (we && addr == AW'(37)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reached_addr37", 32'(found), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", 32'(we), 32'(0));
    chk("mid_rst_addr", 32'(addr), 32'(0));
    chk("mid_rst_load_ready", 32'(load_ready), 32'(1));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_data", 32'(data_out), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_done", 32'(done), 32'(0));
    chk("mid_rel_load_ready", 32'(load_ready), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load_ready", 32'(load_ready), 32'(1));
    chk("rst_we", 32'(we), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_addr", 32'(addr), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_load_ready", 32'(load_ready), 32'(1));
    chk("idle_we", 32'(we), 32'(0));
    chk("idle_re", 32'(re), 32'(0));
    chk("idle_result_valid", 32'(result_valid), 32'(0));
    chk("idle_done", 32'(done), 32'(0));

    for (int i = 0; i < int'(FRAME); i++) img[i] = 8'(i * 3);
    load_frame(1'b1);
    run_frame("A");

    for (int i = 0; i < int'(FRAME); i++) img[i] = 8'($urandom);
    load_frame(1'b0);
    run_frame("B");

    for (int i = 0; i < int'(FRAME); i++) img[i] = 8'($urandom);
    load_frame(1'b0);
    reset_mid_broadcast();

    for (int i = 0; i < int'(FRAME); i++) img[i] = 8'($urandom);
    load_frame(1'b0);
    run_frame("D");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
